// File: rtl/hazard_fetch_unit_if.sv
// Fetch-stage bus: decode-side control, instruction-memory write port and issued-slot outputs.
interface hazard_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              stall_i;
    logic              br_taken_i;
    logic [ADDR_W-1:0] br_target_i;
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [15:0]       wr_data_i;
    logic [15:0]       inst_o;
    logic              inst_valid_o;
    logic [ADDR_W-1:0] pc_o;
    logic [15:0]       bubble_cnt_o;

    modport master (
        output stall_i, br_taken_i, br_target_i, wr_en_i, wr_addr_i, wr_data_i,
        input  inst_o, inst_valid_o, pc_o, bubble_cnt_o
    );

    modport slave (
        input  stall_i, br_taken_i, br_target_i, wr_en_i, wr_addr_i, wr_data_i,
        output inst_o, inst_valid_o, pc_o, bubble_cnt_o
    );
endinterface

// File: rtl/hazard_fetch_unit.sv
// Fetch stage with instruction memory, run-time RAW hazard bubbles and post-branch bubble shadow.
// state   | meaning
// RUN     | issue mem[pc] unless a pending writer matches one of its sources
// BR_WAIT | emit the post-branch bubble shadow, cnt counts remaining bubbles
module hazard_fetch_unit #(
    parameter int    ADDR_W     = 8,
    parameter int    HAZ_WINDOW = 3,
    parameter int    BR_BUBBLES = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic          clk,
    input  logic          rst,
    hazard_fetch_unit_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (BR_BUBBLES < 1) ? 1 : $clog2(BR_BUBBLES + 1);

    typedef enum logic {
        S_RUN     = 1'b0,
        S_BR_WAIT = 1'b1
    } state_t;

    logic [15:0]       mem [DEPTH];
    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       inst_q;
    logic              valid_q;
    logic [ADDR_W-1:0] pc_out_q;
    logic [15:0]       bcnt_q;
    logic [15:0]       bcnt_inc;

    logic [HAZ_WINDOW-1:0]       sb_vld_q, sb_vld_d;
    logic [HAZ_WINDOW-1:0][2:0]  sb_reg_q, sb_reg_d;

    logic [15:0] cur;
    logic [2:0]  op;
    logic        src_a_vld, src_b_vld, dst_vld;
    logic [2:0]  src_a, src_b, dst;
    logic        hazard;
    logic        issue;

    always_ff @(posedge clk) begin
        if (bus.wr_en_i) begin
            mem[bus.wr_addr_i] <= bus.wr_data_i;
        end
    end

    // Register usage of the instruction waiting at pc; all-zero word is a true NOP.
    always_comb begin
        cur       = mem[pc_q];
        op        = cur[15:13];
        src_a_vld = 1'b0;
        src_b_vld = 1'b0;
        dst_vld   = 1'b0;
        src_a     = cur[2:0];
        src_b     = cur[5:3];
        dst       = cur[8:6];
        if (cur != 16'h0000) begin
            case (op)
                3'b000: begin
                    src_a_vld = 1'b1;
                    src_b_vld = 1'b1;
                    dst_vld   = 1'b1;
                end
                3'b001, 3'b010: begin
                    src_b_vld = 1'b1;
                    dst_vld   = 1'b1;
                    dst       = cur[2:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_WINDOW; i++) begin
            if (sb_vld_q[i] && ((src_a_vld && sb_reg_q[i] == src_a) ||
                                (src_b_vld && sb_reg_q[i] == src_b))) begin
                hazard = 1'b1;
            end
        end
    end

    assign issue    = !bus.br_taken_i && (state_q == S_RUN) && !hazard;
    assign bcnt_inc = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;

    // Entry 0 is the slot issued this cycle; the oldest entry falls off the end.
    always_comb begin
        sb_vld_d    = '0;
        sb_reg_d    = '0;
        sb_vld_d[0] = issue && dst_vld;
        sb_reg_d[0] = dst;
        for (int i = 1; i < HAZ_WINDOW; i++) begin
            sb_vld_d[i] = sb_vld_q[i-1];
            sb_reg_d[i] = sb_reg_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            cnt_q    <= '0;
            pc_q     <= '0;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            pc_out_q <= '0;
            bcnt_q   <= '0;
            sb_vld_q <= '0;
            sb_reg_q <= '0;
        end else if (bus.br_taken_i) begin
            pc_q     <= bus.br_target_i;
            state_q  <= S_RUN;
            cnt_q    <= '0;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            bcnt_q   <= bcnt_inc;
            sb_vld_q <= sb_vld_d;
            sb_reg_q <= sb_reg_d;
        end else if (!bus.stall_i) begin
            sb_vld_q <= sb_vld_d;
            sb_reg_q <= sb_reg_d;
            case (state_q)
                S_RUN: begin
                    if (hazard) begin
                        inst_q  <= '0;
                        valid_q <= 1'b0;
                        bcnt_q  <= bcnt_inc;
                    end else begin
                        inst_q   <= cur;
                        valid_q  <= 1'b1;
                        pc_out_q <= pc_q;
                        pc_q     <= pc_q + ADDR_W'(1);
                        if (op == 3'b100 && BR_BUBBLES > 0) begin
                            state_q <= S_BR_WAIT;
                            cnt_q   <= CNT_W'(BR_BUBBLES);
                        end
                    end
                end
                S_BR_WAIT: begin
                    inst_q  <= '0;
                    valid_q <= 1'b0;
                    bcnt_q  <= bcnt_inc;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_RUN;
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

    assign bus.inst_o       = inst_q;
    assign bus.inst_valid_o = valid_q;
    assign bus.pc_o         = pc_out_q;
    assign bus.bubble_cnt_o = bcnt_q;
endmodule

// File: tb/tb_hazard_fetch_unit.sv
// Directed bench for hazard_fetch_unit: hazard bubbles, stalls, branch shadow, redirect, wrap, reset.
module tb_hazard_fetch_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_fetch_unit_if #(.ADDR_W(8)) bus ();

    hazard_fetch_unit #(
        .ADDR_W    (8),
        .HAZ_WINDOW(3),
        .BR_BUBBLES(2),
        .INIT_FILE ("")
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] ei, input logic ev,
                       input logic [7:0] ep, input logic [15:0] eb);
        checks++;
        assert (bus.inst_o === ei) else begin
            errors++;
            $error("FAIL %s inst_o got %h exp %h", tag, bus.inst_o, ei);
        end
        checks++;
        assert (bus.inst_valid_o === ev) else begin
            errors++;
            $error("FAIL %s inst_valid_o got %b exp %b", tag, bus.inst_valid_o, ev);
        end
        checks++;
        assert (bus.pc_o === ep) else begin
            errors++;
            $error("FAIL %s pc_o got %h exp %h", tag, bus.pc_o, ep);
        end
        checks++;
        assert (bus.bubble_cnt_o === eb) else begin
            errors++;
            $error("FAIL %s bubble_cnt_o got %0d exp %0d", tag, bus.bubble_cnt_o, eb);
        end
    endtask

    // Hold reset, clear the whole memory to NOPs, then apply the program words.
    task automatic reset_load(input logic [7:0] a0, input logic [15:0] d0,
                              input logic [7:0] a1, input logic [15:0] d1,
                              input logic [7:0] a2, input logic [15:0] d2);
        rst            = 1'b1;
        bus.wr_en_i    = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.wr_addr_i = 8'(i);
            bus.wr_data_i = 16'h0000;
            tick();
        end
        bus.wr_addr_i = a0; bus.wr_data_i = d0; tick();
        bus.wr_addr_i = a1; bus.wr_data_i = d1; tick();
        bus.wr_addr_i = a2; bus.wr_data_i = d2; tick();
        bus.wr_en_i = 1'b0;
        rst         = 1'b0;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.stall_i     = 1'b0;
        bus.br_taken_i  = 1'b0;
        bus.br_target_i = 8'h00;
        bus.wr_en_i     = 1'b0;
        bus.wr_addr_i   = 8'h00;
        bus.wr_data_i   = 16'h0000;

        // T1: r3 writer then r3 reader
        reset_load(8'h00, 16'h00C0, 8'h01, 16'h0043, 8'h02, 16'h0000);
        chk("t1_reset", 16'h0000, 1'b0, 8'h00, 16'd0);
        tick(); chk("t1_issue0", 16'h00C0, 1'b1, 8'h00, 16'd0);
        tick(); chk("t1_bub1",   16'h0000, 1'b0, 8'h00, 16'd1);
        tick(); chk("t1_bub2",   16'h0000, 1'b0, 8'h00, 16'd2);
        tick(); chk("t1_bub3",   16'h0000, 1'b0, 8'h00, 16'd3);
        tick(); chk("t1_issue1", 16'h0043, 1'b1, 8'h01, 16'd3);

        // T2: independent instructions
        reset_load(8'h00, 16'h0040, 8'h01, 16'h0080, 8'h02, 16'h00C0);
        tick(); chk("t2_pc0", 16'h0040, 1'b1, 8'h00, 16'd0);
        tick(); chk("t2_pc1", 16'h0080, 1'b1, 8'h01, 16'd0);
        tick(); chk("t2_pc2", 16'h00C0, 1'b1, 8'h02, 16'd0);

        // T3: branch shadow with no redirect
        reset_load(8'h05, 16'h8000, 8'h06, 16'h0040, 8'h07, 16'h0000);
        for (int i = 0; i < 5; i++) tick();
        chk("t3_pc4", 16'h0000, 1'b1, 8'h04, 16'd0);
        tick(); chk("t3_br",   16'h8000, 1'b1, 8'h05, 16'd0);
        tick(); chk("t3_bub1", 16'h0000, 1'b0, 8'h05, 16'd1);
        tick(); chk("t3_bub2", 16'h0000, 1'b0, 8'h05, 16'd2);
        tick(); chk("t3_pc6",  16'h0040, 1'b1, 8'h06, 16'd2);

        // T4: redirect during first shadow bubble
        reset_load(8'h05, 16'h8000, 8'h20, 16'h1234, 8'h06, 16'h0040);
        for (int i = 0; i < 6; i++) tick();
        chk("t4_br", 16'h8000, 1'b1, 8'h05, 16'd0);
        bus.br_taken_i  = 1'b1;
        bus.br_target_i = 8'h20;
        tick(); chk("t4_redir_bub", 16'h0000, 1'b0, 8'h05, 16'd1);
        bus.br_taken_i  = 1'b0;
        tick(); chk("t4_target", 16'h1234, 1'b1, 8'h20, 16'd1);

        // T5: stall in the middle of hazard bubbles
        reset_load(8'h00, 16'h00C0, 8'h01, 16'h0043, 8'h02, 16'h0000);
        tick(); chk("t5_issue0", 16'h00C0, 1'b1, 8'h00, 16'd0);
        tick(); chk("t5_bub1",   16'h0000, 1'b0, 8'h00, 16'd1);
        bus.stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); chk("t5_stall", 16'h0000, 1'b0, 8'h00, 16'd1);
        end
        bus.stall_i = 1'b0;
        tick(); chk("t5_bub2",   16'h0000, 1'b0, 8'h00, 16'd2);
        tick(); chk("t5_bub3",   16'h0000, 1'b0, 8'h00, 16'd3);
        tick(); chk("t5_issue1", 16'h0043, 1'b1, 8'h01, 16'd3);

        // T6: pc wrap via redirect to 0xFF, then reset inside the branch shadow
        reset_load(8'hFF, 16'h0040, 8'h00, 16'h8000, 8'h01, 16'h0000);
        bus.br_taken_i  = 1'b1;
        bus.br_target_i = 8'hFF;
        tick(); chk("t6_redir", 16'h0000, 1'b0, 8'h00, 16'd1);
        bus.br_taken_i  = 1'b0;
        tick(); chk("t6_pcff",  16'h0040, 1'b1, 8'hFF, 16'd1);
        tick(); chk("t6_wrap",  16'h8000, 1'b1, 8'h00, 16'd1);
        tick(); chk("t6_bub1",  16'h0000, 1'b0, 8'h00, 16'd2);
        rst = 1'b1;
        tick(); chk("t6_rst",   16'h0000, 1'b0, 8'h00, 16'd0);
        rst = 1'b0;
        tick(); chk("t6_after", 16'h8000, 1'b1, 8'h00, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
